// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Program loader / instruction encoder. Field-level instruction requests
//   arrive over a valid/ready handshake. Each request is encoded into a
//   32-bit word using the CPU opcode map. The words are written to
//   consecutive imem byte addresses, starting from a base address.
//
// Ports
//   clk, reset_n                : clock (rising edge), async active-low reset
//   start, base_addr            : begin a program at base_addr
//   req_valid / req_ready       : request handshake
//   req_op, req_rs, req_rt, req_rd, req_funct, req_imm, req_target, req_last
//                               : request fields
//   imem_we, imem_addr, imem_wdata : one-cycle instruction-memory write
//   busy, done                  : activity flag and end-of-program pulse
//   err, err_code               : sticky error (01 illegal op, 10 overflow)
//   count                       : words written since start
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [5:0]        req_funct,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [5:0] FUNCT_JR = 6'b000111;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_last;
    logic [CNT_W-1:0]  r_count;
    logic              r_we;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_err_code;

    logic              w_illegal;
    logic              w_overflow;
    logic [31:0]       w_enc;

    // Map a request to its machine word; shamt and unused fields stay zero.
    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] word;
        word = 32'd0;
        case (op)
            4'd0:    word = {6'b000000, rs, rt, rd, 5'b00000, funct};
            4'd1:    word = {6'b000000, rs, 15'b0, FUNCT_JR};
            4'd2:    word = {6'b000001, rs, rt, imm};
            4'd3:    word = {6'b000010, rs, rt, imm};
            4'd4:    word = {6'b000011, rs, rt, imm};
            4'd5:    word = {6'b000100, rs, rt, imm};
            4'd6:    word = {6'b000101, rs, rt, imm};
            4'd7:    word = {6'b001001, rs, rt, imm};
            4'd8:    word = {6'b000111, target};
            4'd9:    word = {6'b001000, target};
            default: word = 32'd0;
        endcase
        return word;
    endfunction

    // An RTYPE carrying the JR function code would decode as JR, so reject it.
    assign w_illegal  = (req_op > 4'd9) || ((req_op == 4'd0) && (req_funct == FUNCT_JR));
    assign w_overflow = (r_count == CNT_W'(MAX_WORDS)) && !req_last;
    assign w_enc      = encode(req_op, req_rs, req_rt, req_rd, req_funct, req_imm, req_target);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_last     <= 1'b0;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            // Write strobe and done are single-cycle pulses.
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state    <= S_ACCEPT;
                        r_addr     <= base_addr;
                        r_count    <= '0;
                        r_err      <= 1'b0;
                        r_err_code <= 2'b00;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b1;
                    end else if (r_state == S_DONE) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACCEPT: begin
                    if (req_valid) begin
                        r_ready <= 1'b0;
                        if (w_illegal) begin
                            r_state    <= S_ERROR;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                            r_err_code <= 2'b01;
                        end else if (w_overflow) begin
                            r_state    <= S_ERROR;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                            r_err_code <= 2'b10;
                        end else begin
                            r_state <= S_WRITE;
                            r_wdata <= w_enc;
                            r_last  <= req_last;
                            r_we    <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // Address wraps naturally at 2^ADDR_W.
                    r_addr  <= r_addr + ADDR_W'(4);
                    r_count <= r_count + CNT_W'(1);
                    if (r_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_ACCEPT;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign count      = r_count;

endmodule
